// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline constants and types for the operand-fetch slice.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] word_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/op_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register, x0 never busy.
// A set and a clear of the same index in one cycle leaves the bit set.
module op_scoreboard
   import rv32_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          set_en,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_idx,
   input  logic [AW-1:0] look_a_idx,
   input  logic [AW-1:0] look_b_idx,
   input  logic [AW-1:0] look_c_idx,
   output logic          busy_a,
   output logic          busy_b,
   output logic          busy_c
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en && (clr_idx != REG_ZERO)) busy_d[clr_idx] = 1'b0;
      if (set_en && (set_idx != REG_ZERO)) busy_d[set_idx] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_a = busy_q[look_a_idx];
   assign busy_b = busy_q[look_b_idx];
   assign busy_c = busy_q[look_c_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: RAW/WAW hazard stall, regfile read and a one-entry output slot.
// Optional same-cycle writeback forwarding is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_wr,
   output logic [AW-1:0]   rf_a1,
   output logic [AW-1:0]   rf_a2,
   input  logic [XLEN-1:0] rf_r1,
   input  logic [XLEN-1:0] rf_r2,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [AW-1:0]   out_rd,
   output logic            out_wr
);

   logic          busy_rs1, busy_rs2, busy_rd;
   logic          fwd_rs1, fwd_rs2, fwd_rd;
   logic          haz_rs1, haz_rs2, haz_waw, hazard;
   logic          accept;
   word_t         op1, op2;

   logic          out_valid_q, out_valid_d;
   word_t         out_rs1_q, out_rs1_d;
   word_t         out_rs2_q, out_rs2_d;
   reg_idx_t      out_rd_q, out_rd_d;
   logic          out_wr_q, out_wr_d;

   assign rf_a1 = in_rs1;
   assign rf_a2 = in_rs2;

   op_scoreboard u_sb (
      .clk        (clk),
      .reset      (reset),
      .set_en     (accept && in_wr),
      .set_idx    (in_rd),
      .clr_en     (wb_valid),
      .clr_idx    (wb_rd),
      .look_a_idx (in_rs1),
      .look_b_idx (in_rs2),
      .look_c_idx (in_rd),
      .busy_a     (busy_rs1),
      .busy_b     (busy_rs2),
      .busy_c     (busy_rd)
   );

`ifdef OPFETCH_BYPASS_EN
   assign fwd_rs1 = wb_valid && (wb_rd == in_rs1);
   assign fwd_rs2 = wb_valid && (wb_rd == in_rs2);
   assign fwd_rd  = wb_valid && (wb_rd == in_rd);

   // x0 check comes first so a writeback aimed at x0 can never leak into an operand
   assign op1 = (in_rs1 == REG_ZERO) ? '0 : (fwd_rs1 ? wb_data : rf_r1);
   assign op2 = (in_rs2 == REG_ZERO) ? '0 : (fwd_rs2 ? wb_data : rf_r2);
`else
   logic unused_wb_data;

   assign fwd_rs1        = 1'b0;
   assign fwd_rs2        = 1'b0;
   assign fwd_rd         = 1'b0;
   assign unused_wb_data = ^wb_data;

   assign op1 = (in_rs1 == REG_ZERO) ? '0 : rf_r1;
   assign op2 = (in_rs2 == REG_ZERO) ? '0 : rf_r2;
`endif

   assign haz_rs1 = (in_rs1 != REG_ZERO) && busy_rs1 && !fwd_rs1;
   assign haz_rs2 = (in_rs2 != REG_ZERO) && busy_rs2 && !fwd_rs2;
   assign haz_waw = in_wr && (in_rd != REG_ZERO) && busy_rd && !fwd_rd;
   assign hazard  = haz_rs1 || haz_rs2 || haz_waw;

   // Ready never looks at in_valid, so upstream may gate valid on ready freely
   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_rd_d    = out_rd_q;
      out_wr_d    = out_wr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_rs1_d   = op1;
         out_rs2_d   = op2;
         out_rd_d    = in_rd;
         out_wr_d    = in_wr;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_rs1_q   <= '0;
         out_rs2_q   <= '0;
         out_rd_q    <= REG_ZERO;
         out_wr_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_rs1_q   <= out_rs1_d;
         out_rs2_q   <= out_rs2_d;
         out_rd_q    <= out_rd_d;
         out_wr_q    <= out_wr_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_rs1_val = out_rs1_q;
   assign out_rs2_val = out_rs2_q;
   assign out_rd      = out_rd_q;
   assign out_wr      = out_wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios plus randomized traffic against a register-level model.
module tb_operand_fetch;
   import rv32_pkg::*;

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, in_wr;
   logic [AW-1:0]   in_rs1, in_rs2, in_rd;
   logic [AW-1:0]   rf_a1, rf_a2;
   logic [XLEN-1:0] rf_r1, rf_r2;
   logic            wb_valid;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            out_valid, out_ready, out_wr;
   logic [XLEN-1:0] out_rs1_val, out_rs2_val;
   logic [AW-1:0]   out_rd;

   logic [XLEN-1:0] regs [NREG];
   assign rf_r1 = regs[rf_a1];
   assign rf_r2 = regs[rf_a2];

   operand_fetch dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
      .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_r1(rf_r1), .rf_r2(rf_r2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
      .out_rd(out_rd), .out_wr(out_wr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] v1;
      logic [XLEN-1:0] v2;
      logic [AW-1:0]   rd;
      logic            wr;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   pend [NREG];
   bit   m_slot;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural value an accepted instruction must see for source s
   function automatic logic [XLEN-1:0] model_val(input logic [AW-1:0] s);
      if (s == 0) return '0;
      if (BYP && wb_valid && wb_rd == s) return wb_data;
      return regs[s];
   endfunction

   function automatic bit pending_blocks(input logic [AW-1:0] s);
      return (s != 0) && pend[s] && !(BYP && wb_valid && wb_rd == s);
   endfunction

   // One clock: check ready/valid at the negedge, predict, then advance past the posedge
   task automatic step(output bit acc);
      exp_t            e;
      bit              exp_rdy;
      bit              wbv;
      logic [AW-1:0]   wbi;
      logic [XLEN-1:0] wbd;
      @(negedge clk);
      exp_rdy = !(pending_blocks(in_rs1) || pending_blocks(in_rs2) ||
                  (in_wr && pending_blocks(in_rd))) && (!m_slot || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_slot));
      acc = in_valid && exp_rdy;
      if (acc) begin
         e.v1 = model_val(in_rs1);
         e.v2 = model_val(in_rs2);
         e.rd = in_rd;
         e.wr = in_wr;
         q.push_back(e);
      end
      if (wb_valid && wb_rd != 0) pend[wb_rd] = 1'b0;
      if (acc && in_wr && in_rd != 0) pend[in_rd] = 1'b1;
      m_slot = acc ? 1'b1 : (out_ready ? 1'b0 : m_slot);
      wbv = wb_valid; wbi = wb_rd; wbd = wb_data;
      @(posedge clk);
      #1;
      if (wbv && wbi != 0) regs[wbi] = wbd;
   endtask

   task automatic present(input bit v, input int rs1, input int rs2, input int rd, input bit wr);
      in_valid = v;
      in_rs1   = AW'(rs1);
      in_rs2   = AW'(rs2);
      in_rd    = AW'(rd);
      in_wr    = wr;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      present(1'b0, 0, 0, 0, 1'b0);
      wb_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rs1", out_rs1_val, 32'd0);
      chk("rst_out_rs2", out_rs2_val, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_wr", 32'(out_wr), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
      m_slot = 1'b0;
      reset  = 1'b0;
   endtask

   // Monitor: whatever the slot shows must match the oldest predicted entry, popped on transfer
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL slot: out_valid=1 but no instruction expected at %0t", $time);
            end else begin
               e = q[0];
               chk("out_rs1_val", out_rs1_val, e.v1);
               chk("out_rs2_val", out_rs2_val, e.v2);
               chk("out_rd", 32'(out_rd), 32'(e.rd));
               chk("out_wr", 32'(out_wr), 32'(e.wr));
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      bit              a;
      int              acc_k;
      int              nacc;
      int              cand [$];
      logic [XLEN-1:0] hold1;

      for (int i = 0; i < NREG; i++) regs[i] = $urandom();
      regs[0] = 32'hFFFF_FFFF;
      regs[3] = 32'h11;
      regs[4] = 32'h22;
      wb_rd   = '0;
      wb_data = '0;
      do_reset();

      // Independent issue
      out_ready = 1'b1;
      present(1'b1, 3, 4, 1, 1'b0);
      step(a);
      chk("indep_accept", 32'(a), 32'd1);
      chk("indep_valid", 32'(out_valid), 32'd1);
      chk("indep_rs1", out_rs1_val, 32'h11);
      chk("indep_rs2", out_rs2_val, 32'h22);
      present(1'b0, 0, 0, 0, 1'b0);
      step(a);

      // RAW: writer to x5, dependent waits for its writeback
      present(1'b1, 0, 0, 5, 1'b1);
      step(a);
      chk("raw_writer_accept", 32'(a), 32'd1);
      present(1'b1, 5, 0, 6, 1'b0);
      acc_k = -1;
      for (int k = 0; k < 6; k++) begin
         wb_valid = (k == 3);
         wb_rd    = 5'd5;
         wb_data  = 32'hDEAD_BEEF;
         step(a);
         if (a) begin
            acc_k = k;
            break;
         end
      end
      wb_valid = 1'b0;
      chk("raw_issue_cycle", 32'(acc_k), BYP ? 32'd3 : 32'd4);
      chk("raw_operand", out_rs1_val, 32'hDEAD_BEEF);
      present(1'b0, 0, 0, 0, 1'b0);
      step(a);

      // x0 source and destination
      present(1'b1, 0, 0, 0, 1'b1);
      step(a);
      chk("x0_accept", 32'(a), 32'd1);
      chk("x0_operand", out_rs1_val, 32'd0);
      present(1'b1, 0, 0, 2, 1'b0);
      step(a);
      chk("x0_no_stall", 32'(a), 32'd1);
      present(1'b0, 0, 0, 0, 1'b0);
      step(a);

      // Backpressure
      out_ready = 1'b0;
      present(1'b1, 3, 4, 8, 1'b0);
      step(a);
      hold1 = out_rs1_val;
      chk("bp_first", hold1, 32'h11);
      present(1'b1, 4, 3, 9, 1'b0);
      nacc = 0;
      for (int k = 0; k < 4; k++) begin
         step(a);
         nacc += int'(a);
      end
      chk("bp_stalled", 32'(nacc), 32'd0);
      chk("bp_stable", out_rs1_val, 32'h11);
      out_ready = 1'b1;
      step(a);
      chk("bp_same_cycle", 32'(a), 32'd1);
      chk("bp_next_rs1", out_rs1_val, 32'h22);
      present(1'b0, 0, 0, 0, 1'b0);
      step(a);

      // WAW on x7, then reset discards busy and slot
      present(1'b1, 0, 0, 7, 1'b1);
      step(a);
      acc_k = -1;
      for (int k = 0; k < 6; k++) begin
         wb_valid = (k == 2);
         wb_rd    = 5'd7;
         wb_data  = 32'h77;
         step(a);
         if (a) begin
            acc_k = k;
            break;
         end
      end
      wb_valid = 1'b0;
      chk("waw_issue_cycle", 32'(acc_k), BYP ? 32'd2 : 32'd3);
      present(1'b1, 7, 0, 1, 1'b0);
      step(a);
      chk("waw_busy7_held", 32'(a), 32'd0);
      present(1'b1, 1, 2, 3, 1'b0);
      step(a);
      out_ready = 1'b0;
      present(1'b1, 2, 1, 4, 1'b0);
      step(a);
      do_reset();
      out_ready = 1'b1;
      present(1'b1, 7, 7, 7, 1'b1);
      step(a);
      chk("rst_busy7_cleared", 32'(a), 32'd1);

      // Randomized traffic
      present(1'b0, 0, 0, 0, 1'b0);
      a = 1'b1;
      for (int n = 0; n < 800; n++) begin
         if (a || !in_valid)
            present($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         out_ready = $urandom_range(0, 9) < 7;
         cand.delete();
         for (int r = 1; r < NREG; r++) if (pend[r]) cand.push_back(r);
         wb_valid = 1'b0;
         wb_data  = $urandom();
         if (cand.size() != 0 && $urandom_range(0, 9) < 4) begin
            wb_valid = 1'b1;
            wb_rd    = AW'(cand[$urandom_range(0, cand.size() - 1)]);
         end else if ($urandom_range(0, 19) == 0) begin
            wb_rd    = AW'($urandom_range(0, 7));
            wb_valid = !pend[wb_rd];
         end
         step(a);
      end

      // Drain
      present(1'b0, 0, 0, 0, 1'b0);
      wb_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step(a);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
